// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped instruction cache with one-word frames.
//               Hits are returned combinationally in IDLE; a miss latches
//               the word address and issues a single-word fill to memory.
//               Optional hit/miss statistics are enabled by defining the
//               macro ICACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_dm #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int IW = $clog2(SETS);
   localparam int TW = 30 - IW;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [29:0]        miss_addr_q;
   logic               valid_q [SETS];
   logic [TW-1:0]      tag_q   [SETS];
   logic [31:0]        data_q  [SETS];

   logic [IW-1:0]      w_index;
   logic [TW-1:0]      w_tag;
   logic [IW-1:0]      w_fill_index;
   logic [TW-1:0]      w_fill_tag;
   logic               w_capture;
   logic               w_fill_we;
   logic               w_unused_addr_bits;

   // Byte-offset bits carry no information for a word-wide cache.
   assign w_unused_addr_bits = &imemaddr[1:0];

   assign w_index      = imemaddr[IW+1:2];
   assign w_tag        = imemaddr[31:IW+2];
   assign w_fill_index = miss_addr_q[IW-1:0];
   assign w_fill_tag   = miss_addr_q[29:IW];

   // Frame data is always presented; it is cleared at reset so never X.
   assign imemload = data_q[w_index];

   // Next-state, hit detection and fill handshake.
   always_comb begin
      state_d   = state_q;
      ihit      = 1'b0;
      iREN      = 1'b0;
      iaddr     = 32'h0;
      w_capture = 1'b0;
      w_fill_we = 1'b0;
      case (state_q)
         IDLE: begin
            ihit = imemREN & valid_q[w_index] & (tag_q[w_index] == w_tag);
            if (imemREN && !ihit) begin
               w_capture = 1'b1;
               state_d   = FILL;
            end
         end
         FILL: begin
            iREN  = 1'b1;
            iaddr = {miss_addr_q, 2'b00};
            if (!iwait) begin
               w_fill_we = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, miss address and frame storage; reset wipes every frame.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         miss_addr_q <= 30'h0;
         for (int i = 0; i < SETS; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            data_q[i]  <= 32'h0;
         end
      end else begin
         state_q <= state_d;
         if (w_capture) begin
            miss_addr_q <= imemaddr[31:2];
         end
         if (w_fill_we) begin
            valid_q[w_fill_index] <= 1'b1;
            tag_q[w_fill_index]   <= w_fill_tag;
            data_q[w_fill_index]  <= iload;
         end
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Hit/miss statistics, wrapping naturally at 2^32.
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_cnt_q  <= 32'h0;
         miss_cnt_q <= 32'h0;
      end else begin
         if (ihit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (w_capture) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = 32'h0;
   assign miss_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_dm
// Description : Self-checking bench for icache_dm (SETS=16). A table of
//               reads drives the main flow; hand-written sequences cover
//               mid-fill address change, reset mid-fill and idle requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_dm;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   icache_dm #(.SETS(16)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .ihit       (ihit),
      .imemload   (imemload),
      .iREN       (iREN),
      .iaddr      (iaddr),
      .iwait      (iwait),
      .iload      (iload),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 CLK = ~CLK;

   int          checks = 0;
   int          errors = 0;
   int          exp_hits = 0;
   int          exp_misses = 0;
   logic [31:0] sb_q [$];

   typedef struct {
      logic [31:0] addr;
      int          lat;
      logic        miss;
   } vec_t;

   vec_t vecs [20];

   function automatic logic [31:0] memword(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h0000_0040) return 32'h2402_0005;
      return {w[15:0], ~w[31:16]} ^ 32'h5A00_00A5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_cnt(input string name);
`ifdef ICACHE_STATS_EN
      check({name, " hit_count"}, hit_count, exp_hits);
      check({name, " miss_count"}, miss_count, exp_misses);
`else
      check({name, " hit_count"}, hit_count, 32'h0);
      check({name, " miss_count"}, miss_count, 32'h0);
`endif
   endtask

   // Serve a fill already in progress with lat wait cycles, then expect the hit.
   task automatic serve_fill(input string name, input logic [31:0] a, input int lat);
      int ren_cycles;
      logic [31:0] exp;
      ren_cycles = 0;
      for (int k = 0; k <= lat; k++) begin
         @(negedge CLK);
         iwait = (k < lat);
         iload = memword(a);
         #1;
         if (k == 0 || k == lat) begin
            check({name, " iREN"}, {31'h0, iREN}, 32'h1);
            check({name, " iaddr"}, iaddr, 32'h0000_0100 == 32'h0 ? 32'h0 : {a[31:2], 2'b00});
            check({name, " ihit in fill"}, {31'h0, ihit}, 32'h0);
         end
         if (iREN) ren_cycles++;
      end
      check({name, " fill cycles"}, ren_cycles, lat + 1);
      @(negedge CLK);
      iwait = 1'b1;
      iload = 32'hDEAD_BEEF;
      imemaddr = a;
      #1;
      check({name, " post-fill ihit"}, {31'h0, ihit}, 32'h1);
      check({name, " post-fill iREN"}, {31'h0, iREN}, 32'h0);
      if (sb_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s scoreboard: got empty queue expected one entry", name);
      end else begin
         exp = sb_q.pop_front();
         check({name, " post-fill data"}, imemload, exp);
      end
      exp_hits++;
   endtask

   // One read request: either an immediate hit or a full miss/fill/hit.
   task automatic do_read(input string name, input logic [31:0] a, input int lat, input logic miss);
      logic [31:0] exp;
      @(negedge CLK);
      imemREN  = 1'b1;
      imemaddr = a;
      iwait    = 1'b1;
      iload    = 32'hDEAD_BEEF;
      #1;
      check_cnt(name);
      sb_q.push_back(memword(a));
      if (miss) begin
         check({name, " miss ihit"}, {31'h0, ihit}, 32'h0);
         check({name, " miss iREN"}, {31'h0, iREN}, 32'h0);
         exp_misses++;
         serve_fill(name, a, lat);
      end else begin
         check({name, " ihit"}, {31'h0, ihit}, 32'h1);
         check({name, " iREN"}, {31'h0, iREN}, 32'h0);
         exp = sb_q.pop_front();
         check({name, " data"}, imemload, exp);
         exp_hits++;
      end
   endtask

   initial begin
      vecs[0]  = '{32'h0000_0040, 3, 1'b1};  // cold miss
      vecs[1]  = '{32'h0000_0040, 0, 1'b0};  // warm hits x5
      vecs[2]  = '{32'h0000_0040, 0, 1'b0};
      vecs[3]  = '{32'h0000_0040, 0, 1'b0};
      vecs[4]  = '{32'h0000_0040, 0, 1'b0};
      vecs[5]  = '{32'h0000_0042, 0, 1'b0};  // byte offset ignored
      vecs[6]  = '{32'h0000_0044, 0, 1'b1};
      vecs[7]  = '{32'h0000_0044, 0, 1'b0};
      vecs[8]  = '{32'h0000_0080, 2, 1'b1};  // evicts 0x40 (index 0)
      vecs[9]  = '{32'h0000_0040, 1, 1'b1};  // refill 0x40
      vecs[10] = '{32'h0000_0080, 0, 1'b1};  // thrash
      vecs[11] = '{32'h0000_003C, 1, 1'b1};  // index 15
      vecs[12] = '{32'h0000_003C, 0, 1'b0};
      vecs[13] = '{32'h0000_0044, 0, 1'b0};
      vecs[14] = '{32'hFFFF_FFFC, 0, 1'b1};  // all-ones tag, index 15
      vecs[15] = '{32'hFFFF_FFFF, 0, 1'b0};
      vecs[16] = '{32'h0000_003C, 0, 1'b1};
      vecs[17] = '{32'h0000_0080, 0, 1'b0};
      vecs[18] = '{32'h0000_0044, 0, 1'b0};
      vecs[19] = '{32'h0000_003C, 0, 1'b0};

      RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      #1;
      check("reset ihit", {31'h0, ihit}, 32'h0);
      check("reset imemload", imemload, 32'h0);
      check("reset iREN", {31'h0, iREN}, 32'h0);
      check("reset iaddr", iaddr, 32'h0);
      check("reset hit_count", hit_count, 32'h0);
      check("reset miss_count", miss_count, 32'h0);

      for (int i = 0; i < 20; i++) begin
         do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].lat, vecs[i].miss);
      end

      // Address change mid-fill: 0x100 completes, 0x200 then misses.
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h0000_0100; iwait = 1'b1;
      #1;
      check_cnt("midfill start");
      check("midfill miss ihit", {31'h0, ihit}, 32'h0);
      exp_misses++;
      sb_q.push_back(memword(32'h0000_0100));
      @(negedge CLK);
      imemaddr = 32'h0000_0200; iwait = 1'b1;
      #1;
      check("midfill iaddr held", iaddr, 32'h0000_0100);
      check("midfill ihit", {31'h0, ihit}, 32'h0);
      serve_fill("midfill", 32'h0000_0100, 1);
      do_read("midfill 0x200", 32'h0000_0200, 0, 1'b1);

      // Reset during a fill with memory still busy.
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h0000_0100; iwait = 1'b1;
      #1;
      check("rstfill miss ihit", {31'h0, ihit}, 32'h0);
      @(negedge CLK);
      #1;
      check("rstfill in fill iREN", {31'h0, iREN}, 32'h1);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0; imemREN = 1'b0; iwait = 1'b0; iload = 32'hBAD0_BAD0;
      #1;
      check("rstfill iREN", {31'h0, iREN}, 32'h0);
      check("rstfill iaddr", iaddr, 32'h0);
      check("rstfill imemload", imemload, 32'h0);
      exp_hits = 0; exp_misses = 0;
      sb_q.delete();
      check_cnt("rstfill");
      do_read("rstfill reread", 32'h0000_0100, 1, 1'b1);

      // Idle request: no hit, no fill, no counter change.
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         imemREN = 1'b0; imemaddr = 32'h0000_0100; iwait = 1'b0;
         #1;
         check("idle ihit", {31'h0, ihit}, 32'h0);
         check("idle iREN", {31'h0, iREN}, 32'h0);
         check_cnt("idle");
      end
      do_read("after idle", 32'h0000_0100, 0, 1'b1 == 1'b0);
      @(negedge CLK);
      imemREN = 1'b0;
      #1;
      check_cnt("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
